latch_bank_write_ctrl: RTL and testbench

// Arbitrates NREQ requesters for write access to a bank of NLAT level-sensitive D latches (shared D bus, one enable per latch).

---
 rtl/latch_bank_write_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_latch_bank_write_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/latch_bank_write_ctrl.sv
// latch_bank_write_ctrl
//   Round-robin arbiter and write sequencer for a bank of level-sensitive D latches that
//   share one D bus. Each write is sequenced as data setup, then a one-hot enable pulse,
//   then data hold, so a latch only ever sees a stable D while it is transparent.
//
// Ports
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset
//   req_i       write request, one bit per requester
//   req_addr_i  latch index, requester i uses [i*AW +: AW]
//   req_data_i  write data, requester i uses [i*DW +: DW]
//   ack_o       one-cycle completion pulse to the granted requester
//   err_o       pulses with ack_o when the captured address is >= NLAT
//   lat_d_o     shared D bus to the latch bank
//   lat_en_o    one-hot latch enables, straight from flops
//   busy_o      high whenever a write is in progress
module latch_bank_write_ctrl #(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned NLAT      = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned OPEN_CYC  = 2,
    parameter int unsigned HOLD_CYC  = 1,
    localparam int unsigned AW       = $clog2(NLAT)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*AW-1:0]   req_addr_i,
    input  logic [NREQ*DW-1:0]   req_data_i,
    output logic [NREQ-1:0]      ack_o,
    output logic                 err_o,
    output logic [DW-1:0]        lat_d_o,
    output logic [NLAT-1:0]      lat_en_o,
    output logic                 busy_o
);

    localparam int unsigned IW   = $clog2(NREQ);
    localparam int unsigned MAXC = (SETUP_CYC > OPEN_CYC)
                                   ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                   : ((OPEN_CYC > HOLD_CYC) ? OPEN_CYC : HOLD_CYC);
    localparam int unsigned CW   = $clog2(MAXC + 1);

    // Counters are loaded with CYC-1 on entry and the state exits when they reach zero.
    localparam logic [CW-1:0] SetupLd = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] OpenLd  = CW'(OPEN_CYC - 1);
    localparam logic [CW-1:0] HoldLd  = CW'(HOLD_CYC - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StOpen, StHold, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   win_q, win_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [DW-1:0]   lat_d_q, lat_d_d;
    logic [NLAT-1:0] lat_en_q, lat_en_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;

    logic            found;
    logic [IW-1:0]   pick;
    logic [NLAT-1:0] addr_onehot;
    logic            addr_ok;
    logic [NREQ-1:0] win_onehot;

    // Round-robin search starting at rr_q, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            int unsigned idx;
            idx = (int'(rr_q) + i) % NREQ;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    // Out-of-range addresses match no bit, so the enable vector stays zero for them.
    always_comb begin
        for (int unsigned j = 0; j < NLAT; j++) begin
            addr_onehot[j] = (addr_q == AW'(j));
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            win_onehot[i] = (win_q == IW'(i));
        end
        addr_ok = (int'(addr_q) < int'(NLAT));
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        addr_d   = addr_q;
        rr_d     = rr_q;
        lat_d_d  = lat_d_q;
        lat_en_d = lat_en_q;
        ack_d    = '0;
        err_d    = 1'b0;
        busy_d   = busy_q;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    win_d   = pick;
                    addr_d  = req_addr_i[int'(pick)*AW +: AW];
                    lat_d_d = req_data_i[int'(pick)*DW +: DW];
                    cnt_d   = SetupLd;
                    busy_d  = 1'b1;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    lat_en_d = addr_onehot;
                    cnt_d    = OpenLd;
                    state_d  = StOpen;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StOpen: begin
                if (cnt_q == '0) begin
                    lat_en_d = '0;
                    cnt_d    = HoldLd;
                    state_d  = StHold;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    ack_d   = win_onehot;
                    err_d   = !addr_ok;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                rr_d    = (int'(win_q) == int'(NREQ) - 1) ? '0 : win_q + 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                lat_en_d = '0;
                busy_d   = 1'b0;
                state_d  = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            win_q    <= '0;
            addr_q   <= '0;
            rr_q     <= '0;
            lat_d_q  <= '0;
            lat_en_q <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            addr_q   <= addr_d;
            rr_q     <= rr_d;
            lat_d_q  <= lat_d_d;
            lat_en_q <= lat_en_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign ack_o    = ack_q;
    assign err_o    = err_q;
    assign lat_d_o  = lat_d_q;
    assign lat_en_o = lat_en_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_latch_bank_write_ctrl.sv
// Directed bench for latch_bank_write_ctrl: default DUT (a), NLAT=3 DUT (b) for the
// out-of-range case, and SETUP/OPEN/HOLD = 3/1/2 DUT (c) for timing.
module tb_latch_bank_write_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // DUT a: defaults
    logic [1:0]  req_a = '0;
    logic [3:0]  addr_a = '0;
    logic [15:0] data_a = '0;
    logic [1:0]  ack_a;
    logic        err_a;
    logic [7:0]  latd_a;
    logic [3:0]  laten_a;
    logic        busy_a;

    // DUT b: NLAT=3
    logic [1:0]  req_b = '0;
    logic [3:0]  addr_b = '0;
    logic [15:0] data_b = '0;
    logic [1:0]  ack_b;
    logic        err_b;
    logic [7:0]  latd_b;
    logic [2:0]  laten_b;
    logic        busy_b;

    // DUT c: 3/1/2 timing
    logic [1:0]  req_c = '0;
    logic [3:0]  addr_c = '0;
    logic [15:0] data_c = '0;
    logic [1:0]  ack_c;
    logic        err_c;
    logic [7:0]  latd_c;
    logic [3:0]  laten_c;
    logic        busy_c;

    latch_bank_write_ctrl u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .req_addr_i(addr_a), .req_data_i(data_a),
        .ack_o(ack_a), .err_o(err_a), .lat_d_o(latd_a), .lat_en_o(laten_a), .busy_o(busy_a)
    );

    latch_bank_write_ctrl #(.NLAT(3)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .req_addr_i(addr_b), .req_data_i(data_b),
        .ack_o(ack_b), .err_o(err_b), .lat_d_o(latd_b), .lat_en_o(laten_b), .busy_o(busy_b)
    );

    latch_bank_write_ctrl #(.SETUP_CYC(3), .OPEN_CYC(1), .HOLD_CYC(2)) u_dut_c (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_c), .req_addr_i(addr_c), .req_data_i(data_c),
        .ack_o(ack_c), .err_o(err_c), .lat_d_o(latd_c), .lat_en_o(laten_c), .busy_o(busy_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for any ack on DUT a, then compare the pulse.
    task automatic wait_ack_a(input string tag, input logic [1:0] exp);
        int n = 0;
        while (ack_a == 2'b00 && n < 12) begin
            tick();
            n++;
        end
        check(tag, 32'(ack_a), 32'(exp));
    endtask

    // Invariants on DUT a: enables one-hot-or-zero, D stable across an open window.
    logic [3:0] laten_prev = '0;
    logic [7:0] latd_prev = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (laten_a != 4'b0) check("onehot", 32'($countones(laten_a)), 32'd1);
            if (laten_a != 4'b0 && laten_prev != 4'b0) check("d_stable", 32'(latd_a),
                                                             32'(latd_prev));
        end
        laten_prev = laten_a;
        latd_prev  = latd_a;
    end

    initial begin
        #12 rst_n = 1'b1;
        #1;
        check("rst_ack", 32'(ack_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_laten", 32'(laten_a), 32'd0);
        check("rst_latd", 32'(latd_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);

        // 1: single write, requester 0, addr 2, data A5
        req_a = 2'b01; addr_a = 4'd2; data_a = 16'h00A5;
        tick();  // edge 1: capture
        check("t1_latd_e1", 32'(latd_a), 32'hA5);
        check("t1_busy_e1", 32'(busy_a), 32'd1);
        check("t1_laten_e1", 32'(laten_a), 32'd0);
        tick();  // edge 2
        check("t1_laten_e2", 32'(laten_a), 32'b0100);
        tick();  // edge 3
        check("t1_laten_e3", 32'(laten_a), 32'b0100);
        check("t1_ack_e3", 32'(ack_a), 32'd0);
        tick();  // edge 4
        check("t1_laten_e4", 32'(laten_a), 32'd0);
        check("t1_ack_e4", 32'(ack_a), 32'd0);
        tick();  // edge 5
        check("t1_ack_e5", 32'(ack_a), 32'b01);
        check("t1_err_e5", 32'(err_a), 32'd0);
        check("t1_busy_e5", 32'(busy_a), 32'd1);
        req_a = 2'b00;
        tick();  // edge 6
        check("t1_ack_e6", 32'(ack_a), 32'd0);
        check("t1_busy_e6", 32'(busy_a), 32'd0);
        check("t1_latd_keep", 32'(latd_a), 32'hA5);

        // 2: contention from reset, pointer at 0
        rst_n = 1'b0; #2 rst_n = 1'b1;
        req_a = 2'b11; addr_a = {2'd1, 2'd0}; data_a = 16'h2211;
        tick();
        check("t2_first_latd", 32'(latd_a), 32'h11);
        wait_ack_a("t2_first_ack", 2'b01);
        req_a[0] = 1'b0;
        tick();
        check("t2_idle_busy", 32'(busy_a), 32'd0);
        tick();
        check("t2_second_latd", 32'(latd_a), 32'h22);
        wait_ack_a("t2_second_ack", 2'b10);
        req_a = 2'b11;
        tick();
        tick();
        check("t2_wrap_latd", 32'(latd_a), 32'h11);
        wait_ack_a("t2_wrap_ack", 2'b01);
        req_a = 2'b00;
        tick();

        // 4: reset while OPEN, pointer currently 1
        req_a = 2'b01; addr_a = 4'd1; data_a = 16'h005A;
        tick();
        tick();
        check("t4_open_laten", 32'(laten_a), 32'b0010);
        req_a = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_laten", 32'(laten_a), 32'd0);
        check("t4_rst_latd", 32'(latd_a), 32'd0);
        check("t4_rst_busy", 32'(busy_a), 32'd0);
        rst_n = 1'b1;
        req_a = 2'b11; data_a = 16'h8877; addr_a = 4'd0;
        tick();
        check("t4_ptr0_latd", 32'(latd_a), 32'h77);
        wait_ack_a("t4_ptr0_ack", 2'b01);
        req_a = 2'b00;
        tick();

        // 5: input churn during SETUP
        req_a = 2'b01; addr_a = 4'd3; data_a = 16'h0066;
        tick();
        data_a = 16'h00FF; req_a = 2'b00;
        tick();
        check("t5_latd_open", 32'(latd_a), 32'h66);
        check("t5_laten_open", 32'(laten_a), 32'b1000);
        tick();
        tick();
        check("t5_latd_hold", 32'(latd_a), 32'h66);
        check("t5_laten_hold", 32'(laten_a), 32'd0);
        tick();
        check("t5_ack", 32'(ack_a), 32'b01);
        check("t5_latd_ack", 32'(latd_a), 32'h66);
        tick();

        // 3: out-of-range address on NLAT=3
        req_b = 2'b01; addr_b = 4'd3; data_b = 16'h003C;
        tick();
        check("t3_latd", 32'(latd_b), 32'h3C);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_laten", 32'(laten_b), 32'd0);
            check("t3_noack", 32'(ack_b), 32'd0);
        end
        tick();
        req_b = 2'b00;
        check("t3_ack", 32'(ack_b), 32'b01);
        check("t3_err", 32'(err_b), 32'd1);
        check("t3_laten_end", 32'(laten_b), 32'd0);
        tick();
        check("t3_ack_clr", 32'(ack_b), 32'd0);
        check("t3_err_clr", 32'(err_b), 32'd0);

        // 6: SETUP/OPEN/HOLD = 3/1/2
        req_c = 2'b01; addr_c = 4'd2; data_c = 16'h00C3;
        tick();  // k
        tick();  // k+1
        check("t6_laten_k1", 32'(laten_c), 32'd0);
        tick();  // k+2
        check("t6_laten_k2", 32'(laten_c), 32'd0);
        tick();  // k+3
        check("t6_laten_k3", 32'(laten_c), 32'b0100);
        tick();  // k+4
        check("t6_laten_k4", 32'(laten_c), 32'd0);
        tick();  // k+5
        check("t6_ack_k5", 32'(ack_c), 32'd0);
        tick();  // k+6
        check("t6_ack_k6", 32'(ack_c), 32'b01);
        check("t6_err_k6", 32'(err_c), 32'd0);
        req_c = 2'b00;
        tick();  // k+7
        check("t6_ack_k7", 32'(ack_c), 32'd0);
        check("t6_busy_k7", 32'(busy_c), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
